booth4_seq_mult16: RTL
======================

# booth4_seq_mult16

Iterative radix-4 Booth multiplier for signed 16×16 operands. It retires one Booth digit per clock through a single partial-product selector, in 8 cycles. It is the area-minimal counterpart of the combinational Booth4/Wallace 16×16 multiplier: same operand and product format, same digit encoding. It sits behind a valid/ready stream on both sides, so either implementation can be swapped into a datapath and cross-checked against the other.

## Interface
- `WIDTH`, 16: operand width; fixed at 16, present for the shared definitions only.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: reset, synchronous, active-low.
- `in_valid` input, 1: operand pair valid.
- `in_ready` output, 1: block can accept operands; combinational, `(state==IDLE) & rst_n`.
- `a` input, 16: multiplicand, two's complement.
- `b` input, 16: multiplier, two's complement.
- `out_valid` output, 1: product valid; registered.
- `out_ready` input, 1: consumer accepts product.
- `p` output, 32: signed product `a*b`; registered.
- `busy` output, 1: high in CALC or DONE; registered.

## Operation
- States:
  - IDLE: `in_ready=1`.
  - CALC: 8 digit cycles, counter `i` runs 0..7.
  - DONE: `out_valid=1`, `p` held.
- IDLE→CALC on `in_valid & in_ready` at the edge.
  - Latch `A=a`, `B_ext={b,1'b0}` (17 bits).
  - Clear the 32-bit accumulator `acc`; set `i=0`.
- Each CALC cycle:
  - Digit `d = B_ext[2i+2:2i]`.
  - Decode `d`:
    - 000 or 111 → 0.
    - 001 or 010 → +A.
    - 011 → +2A.
    - 100 → −2A.
    - 101 or 110 → −A.
  - `pp` is 18-bit signed; −2A of −32768 is +65536, so 17 bits do not suffice.
  - `acc <= acc + (sext32(pp) << 2i)`, modulo 2^32.
  - `i <= i+1`.
- CALC→DONE on the edge that processes `i=7`; at that edge `p <= acc` final and `out_valid <= 1`.
- DONE→IDLE on `out_valid & out_ready`; at that edge `out_valid <= 0`.
  - `p` keeps its last value until the next product.
- No new operand is accepted in CALC or DONE.
- `in_valid` is ignored while `in_ready=0`, and `a`/`b` may change freely then.
- Reset (`rst_n=0` at any edge, including mid-CALC or in DONE):
  - The operation in flight is discarded.
  - State goes to IDLE.
  - `p`, `acc`, `i`, `out_valid` and `busy` go to 0.
  - `in_ready` reads 0 while `rst_n=0`.
- The result is exact for all inputs; the extreme case −32768×−32768 = 0x4000_0000 fits the 32-bit field.

## Timing
- Accept at the edge ending cycle 0.
- CALC occupies cycles 1–8.
- `out_valid=1` and `p` are valid from cycle 9.
- If `out_ready=1` in cycle 9, the state is IDLE in cycle 10 and the next accept is possible at the end of cycle 10.
- Minimum initiation interval is 10 cycles; each cycle of `out_ready=0` in DONE extends it by one.
- `out_valid` and `p` are stable while `out_ready=0`.
- Neither `in_ready` nor `out_valid` depends combinationally on `out_ready` or `in_valid`.

## Structure
- Shared header `booth4_defs.vh`, common with the combinational multiplier:
  - `WIDTH=16`, `PP_W=18`, `N_DIGITS=8`, product width 32.
  - State encodings IDLE/CALC/DONE (2-bit).
  - Booth digit opcodes.
- One sub-module, `booth4_pp_sel`: 3-bit digit plus 16-bit `A` in, 18-bit signed `pp` out.
  - Purely combinational.
  - Internally uses the `neg = d[2]`, `one = d[1]^d[0]` and `two`/`zero` detect decomposition of the combinational design.
  - Unit-testable on its own with all 8 digits × corner `A` values.
- Top: FSM, 3-bit digit counter, 17-bit `B_ext`, 16-bit `A`, 32-bit `acc`, output registers.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles.
  - Required: `in_ready=0`, `out_valid=0`, `p=0`, `busy=0`.
  - After release: `in_ready=1` in the next cycle.
- Basic: `a=3`, `b=−5`, accept in cycle 0, `out_ready=1`.
  - Required: `out_valid` rises in cycle 9, `p=0xFFFF_FFF1` (−15), IDLE in cycle 10.
- Corners, each in its own transaction:
  - −32768×−32768 → 0x4000_0000.
  - −32768×32767 → 0xC000_8000.
  - 32767×32767 → 0x3FFF_0001.
  - 0×−1 → 0.
- Backpressure: `a=100`, `b=200`, hold `out_ready=0` for 5 cycles after `out_valid`.
  - Required: `p=20000` stable and `in_ready=0` throughout.
  - Required: `in_valid` pulses during this window are ignored.
- Reset mid-CALC: assert `rst_n=0` in cycle 4 of an operation.
  - Required: IDLE and all outputs 0 on the next edge, and no `out_valid` from the aborted operation.
  - Required: after release, a fresh operation `a=−7`, `b=9` completes with −63.
- Random: ≥10k back-to-back random pairs with `out_ready` toggled randomly.
  - Required: every product matches a signed 32-bit reference model, in order, and each is delivered exactly once.

Source files
------------

// File: rtl/booth4_seq_mult16_pkg.sv
// Shared definitions for the radix-4 Booth multipliers: widths, FSM states, digit codes.
// The combinational Booth4/Wallace variant uses the same package.
package booth4_seq_mult16_pkg;

  localparam int OP_W     = 16;
  localparam int PP_W     = 18;
  localparam int N_DIGITS = 8;
  localparam int P_W      = 2 * OP_W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // The only two digits that select a doubled multiplicand.
  localparam logic [2:0] DIG_P2 = 3'b011;
  localparam logic [2:0] DIG_M2 = 3'b100;

  function automatic logic [P_W-1:0] sext_pp(input logic [PP_W-1:0] pp);
    return {{(P_W - PP_W){pp[PP_W-1]}}, pp};
  endfunction

endpackage

// File: rtl/booth4_seq_mult16_pp_sel.sv
// Radix-4 Booth partial-product selector: one 3-bit digit and the multiplicand in,
// an 18-bit signed partial product out. Purely combinational.
module booth4_pp_sel
  import booth4_seq_mult16_pkg::*;
(
  input  logic [2:0]      digit,
  input  logic [OP_W-1:0] a,
  output logic [PP_W-1:0] pp
);

  logic            neg;
  logic            one;
  logic            two;
  logic            zero;
  logic [PP_W-1:0] a_ext;
  logic [PP_W-1:0] mag;

  assign neg  = digit[2];
  assign one  = digit[1] ^ digit[0];
  assign two  = (digit == DIG_P2) | (digit == DIG_M2);
  assign zero = ~one & ~two;

  assign a_ext = {{(PP_W - OP_W){a[OP_W-1]}}, a};

  // 18 bits so that -2 * (-32768) = +65536 is representable.
  always_comb begin
    mag = '0;
    if (zero)     mag = '0;
    else if (two) mag = a_ext << 1;
    else          mag = a_ext;
  end

  assign pp = neg ? (~mag + 1'b1) : mag;

endmodule

// File: rtl/booth4_seq_mult16.sv
// Iterative radix-4 Booth 16x16 signed multiplier: one Booth digit per clock,
// 8 digit cycles, valid/ready on operand and product sides.
module booth4_seq_mult16
  import booth4_seq_mult16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH:0]  b_ext;
  logic [2:0]      cnt;
  logic [4:0]      bit_idx;
  logic [2:0]      digit;
  logic [PP_W-1:0] pp;
  logic [P_W-1:0]  pp_shift;
  logic [P_W-1:0]  acc;
  logic [P_W-1:0]  acc_nxt;
  logic            last_digit;

  assign in_ready   = (state == IDLE) & rst_n;
  assign last_digit = (cnt == 3'(N_DIGITS - 1));

  assign bit_idx = {1'b0, cnt, 1'b0};
  assign digit   = b_ext[bit_idx +: 3];

  booth4_pp_sel u_pp_sel (
    .digit (digit),
    .a     (a_reg),
    .pp    (pp)
  );

  assign pp_shift = sext_pp(pp) << bit_idx;
  assign acc_nxt  = acc + pp_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)   state_nxt = CALC;
      CALC:    if (last_digit) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_ext     <= '0;
      cnt       <= '0;
      acc       <= '0;
      p         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_ext <= {b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 3'd1;
          // Product register is loaded straight from the final sum, not one cycle later.
          if (last_digit) begin
            p         <= acc_nxt;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
